// File: rtl/pipe_sched_if.sv
// Bundles the game-side inputs and the pipe scheduler outputs. The testbench or
// top level drives the master side; pipe_sched sits on the slave side.
interface pipe_sched_if;
    logic        i_animate;
    logic        i_flap;
    logic [11:0] i_bird_x1;
    logic [11:0] i_bird_x2;
    logic [11:0] i_bird_y1;
    logic [11:0] i_bird_y2;

    logic [1:0]  o_state;
    logic [11:0] o_pipe_x1 [3];
    logic [11:0] o_pipe_x2 [3];
    logic [11:0] o_gap_y1  [3];
    logic [11:0] o_gap_y2  [3];
    logic        o_pipe_vis;
    logic        o_bird_en;
    logic        o_bird_hold;
    logic [7:0]  o_score;
    logic        o_hit;

    modport master (
        output i_animate, i_flap, i_bird_x1, i_bird_x2, i_bird_y1, i_bird_y2,
        input  o_state, o_pipe_x1, o_pipe_x2, o_gap_y1, o_gap_y2,
        input  o_pipe_vis, o_bird_en, o_bird_hold, o_score, o_hit
    );

    modport slave (
        input  i_animate, i_flap, i_bird_x1, i_bird_x2, i_bird_y1, i_bird_y2,
        output o_state, o_pipe_x1, o_pipe_x2, o_gap_y1, o_gap_y2,
        output o_pipe_vis, o_bird_en, o_bird_hold, o_score, o_hit
    );
endinterface

// File: rtl/pipe_sched.sv
// pipe_sched: game state machine plus three scrolling pipe columns with random
// gap heights, scoring and collision detection. On the IDLE->PLAY transition all
// three gaps come from one LFSR sample, offset by k*37 (mod 256) for pipe k.
module pipe_sched #(
    parameter int PIPE_W      = 40,
    parameter int GAP_H       = 120,
    parameter int GAP_MIN     = 60,
    parameter int SPACING     = 220,
    parameter int SCROLL      = 2,
    parameter int SCREEN_W    = 640,
    parameter int FLOOR_Y     = 465,
    parameter int DEAD_FRAMES = 60
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    pipe_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DEAD = 2'b10,
        OVER = 2'b11
    } state_t;

    localparam int               CNT_W     = $clog2(DEAD_FRAMES + 1);
    localparam logic [11:0]      PIPE_W_V  = 12'(PIPE_W);
    localparam logic [11:0]      SCROLL_V  = 12'(SCROLL);
    localparam logic [11:0]      WRAP_V    = 12'(3 * SPACING - SCROLL);
    localparam logic [11:0]      GAP_MIN_V = 12'(GAP_MIN);
    localparam logic [11:0]      GAP_H_V   = 12'(GAP_H);
    localparam logic [11:0]      FLOOR_V   = 12'(FLOOR_Y);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_FRAMES - 1);

    state_t           state;
    state_t           state_next;
    logic             sync_q1;
    logic             sync_q2;
    logic [7:0]       lfsr;
    logic [11:0]      x2          [3];
    logic [11:0]      x1          [3];
    logic [11:0]      gap_y1      [3];
    logic [11:0]      gap_y2      [3];
    logic [11:0]      x2_scrolled [3];
    logic [2:0]       respawn;
    logic [2:0]       crossed;
    logic [8:0]       score_sum;
    logic [7:0]       score_sat;
    logic [7:0]       score;
    logic [CNT_W-1:0] dead_cnt;
    logic             hit_any;
    logic             hit;
    logic             hit_q;
    logic             pipe_vis;
    logic             bird_en;
    logic             bird_hold;

    // Reset release is re-timed through two flops; nothing moves until sync_q2 is high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= 1'b1;
            sync_q2 <= sync_q1;
        end
    end

    // Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seeded non-zero so it never locks.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr <= 8'hA5;
        end else if (sync_q2) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Left edges clamp at zero while a column slides off the left side of the screen.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            x1[k] = (x2[k] >= PIPE_W_V) ? x2[k] - PIPE_W_V : 12'd0;
        end
    end

    // Candidate scroll positions, crossings past the bird, saturating score and collision test.
    always_comb begin
        hit_any   = (bus.i_bird_y2 >= FLOOR_V);
        score_sum = {1'b0, score};
        respawn   = 3'b000;
        crossed   = 3'b000;
        for (int k = 0; k < 3; k++) begin
            respawn[k]     = (x2[k] <= SCROLL_V);
            x2_scrolled[k] = respawn[k] ? x2[k] + WRAP_V : x2[k] - SCROLL_V;
            crossed[k]     = (x2[k] >= bus.i_bird_x1) && (x2_scrolled[k] < bus.i_bird_x1);
            score_sum      = score_sum + {8'd0, crossed[k]};
            if ((bus.i_bird_x2 > x1[k]) && (bus.i_bird_x1 < x2[k]) &&
                ((bus.i_bird_y1 < gap_y1[k]) || (bus.i_bird_y2 > gap_y2[k]))) begin
                hit_any = 1'b1;
            end
        end
        score_sat = score_sum[8] ? 8'd255 : score_sum[7:0];
        hit       = (state == PLAY) && hit_any;
    end

    // Next-state logic for the game phases.
    always_comb begin
        state_next = state;
        if (sync_q2) begin
            case (state)
                IDLE: if (bus.i_flap) state_next = PLAY;
                PLAY: if (hit) state_next = DEAD;
                DEAD: if (bus.i_animate && (dead_cnt == DEAD_LAST)) state_next = OVER;
                OVER: if (bus.i_flap) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // State register plus the per-phase enables, registered from the upcoming state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            pipe_vis  <= 1'b0;
            bird_en   <= 1'b0;
            bird_hold <= 1'b1;
        end else begin
            state     <= state_next;
            pipe_vis  <= (state_next != IDLE);
            bird_en   <= (state_next == PLAY);
            bird_hold <= (state_next == IDLE);
        end
    end

    // Pipe positions, gaps, score, death counter and the hit pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 3; k++) begin
                x2[k]     <= 12'(SCREEN_W + k * SPACING);
                gap_y1[k] <= GAP_MIN_V;
                gap_y2[k] <= GAP_MIN_V + GAP_H_V;
            end
            score    <= 8'd0;
            dead_cnt <= '0;
            hit_q    <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            if (sync_q2) begin
                case (state)
                    IDLE: begin
                        if (bus.i_flap) begin
                            for (int k = 0; k < 3; k++) begin
                                x2[k]     <= 12'(SCREEN_W + k * SPACING);
                                gap_y1[k] <= GAP_MIN_V + {4'd0, 8'(lfsr + 8'(k * 37))};
                                gap_y2[k] <= GAP_MIN_V + GAP_H_V + {4'd0, 8'(lfsr + 8'(k * 37))};
                            end
                            score <= 8'd0;
                        end
                    end
                    PLAY: begin
                        if (hit) begin
                            hit_q    <= 1'b1;
                            dead_cnt <= '0;
                        end else if (bus.i_animate) begin
                            for (int k = 0; k < 3; k++) begin
                                x2[k] <= x2_scrolled[k];
                                if (respawn[k]) begin
                                    gap_y1[k] <= GAP_MIN_V + {4'd0, lfsr};
                                    gap_y2[k] <= GAP_MIN_V + GAP_H_V + {4'd0, lfsr};
                                end
                            end
                            score <= score_sat;
                        end
                    end
                    DEAD: begin
                        if (bus.i_animate) dead_cnt <= dead_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_state     = state;
    assign bus.o_pipe_vis  = pipe_vis;
    assign bus.o_bird_en   = bird_en;
    assign bus.o_bird_hold = bird_hold;
    assign bus.o_score     = score;
    assign bus.o_hit       = hit_q;

    for (genvar k = 0; k < 3; k++) begin : g_out
        assign bus.o_pipe_x1[k] = x1[k];
        assign bus.o_pipe_x2[k] = x2[k];
        assign bus.o_gap_y1[k]  = gap_y1[k];
        assign bus.o_gap_y2[k]  = gap_y2[k];
    end

endmodule

// File: tb/tb_pipe_sched.sv
// Testbench for pipe_sched: drives randomized frames and flaps, predicting pipes,
// gaps and score with a behavioural game model.
module tb_pipe_sched;
    localparam int PIPE_W      = 40;
    localparam int GAP_H       = 120;
    localparam int GAP_MIN     = 60;
    localparam int SPACING     = 220;
    localparam int SCROLL      = 2;
    localparam int SCREEN_W    = 640;
    localparam int FLOOR_Y     = 465;
    localparam int DEAD_FRAMES = 60;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    pipe_sched_if bus();

    pipe_sched #(
        .PIPE_W(PIPE_W), .GAP_H(GAP_H), .GAP_MIN(GAP_MIN), .SPACING(SPACING),
        .SCROLL(SCROLL), .SCREEN_W(SCREEN_W), .FLOOR_Y(FLOOR_Y), .DEAD_FRAMES(DEAD_FRAMES)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         m_x2  [3];
    int         m_gap [3];
    int         m_score;
    logic [7:0] m_lfsr;
    int         m_sync;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic int x1_of(input int x2);
        return (x2 >= PIPE_W) ? x2 - PIPE_W : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            if (m_sync >= 2) m_lfsr = lfsr_next(m_lfsr);
            else m_sync++;
        end
        #1;
    endtask

    task automatic set_bird(input int bx1, input int bx2, input int by1, input int by2);
        bus.i_bird_x1 = 12'(bx1);
        bus.i_bird_x2 = 12'(bx2);
        bus.i_bird_y1 = 12'(by1);
        bus.i_bird_y2 = 12'(by2);
    endtask

    task automatic model_reset();
        m_lfsr  = 8'hA5;
        m_sync  = 0;
        m_score = 0;
        for (int k = 0; k < 3; k++) begin
            m_x2[k]  = SCREEN_W + k * SPACING;
            m_gap[k] = GAP_MIN;
        end
    endtask

    task automatic model_start();
        for (int k = 0; k < 3; k++) begin
            m_x2[k]  = SCREEN_W + k * SPACING;
            m_gap[k] = GAP_MIN + ((int'(m_lfsr) + 37 * k) % 256);
        end
        m_score = 0;
    endtask

    task automatic model_scroll(input int bx1, output int crosses);
        crosses = 0;
        for (int k = 0; k < 3; k++) begin
            int old_x;
            int new_x;
            old_x = m_x2[k];
            if (old_x <= SCROLL) begin
                new_x    = old_x - SCROLL + 3 * SPACING;
                m_gap[k] = GAP_MIN + int'(m_lfsr);
            end else begin
                new_x = old_x - SCROLL;
            end
            if (old_x >= bx1 && new_x < bx1) begin
                crosses++;
                if (m_score < 255) m_score++;
            end
            m_x2[k] = new_x;
        end
    endtask

    task automatic test_reset();
        bus.i_animate = 1'b0;
        bus.i_flap    = 1'b0;
        set_bird(0, 0, 0, 0);
        #3 rst_n = 1'b0;
        model_reset();
        #20;
        n_cmp++; if (bus.o_state !== 2'b00) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", bus.o_state); end
        n_cmp++; if (bus.o_score !== 8'd0) begin n_fail++; $display("FAIL rst_score: got %0d expected 0", bus.o_score); end
        n_cmp++; if (bus.o_hit !== 1'b0) begin n_fail++; $display("FAIL rst_hit: got %0d expected 0", bus.o_hit); end
        n_cmp++; if ({bus.o_pipe_vis, bus.o_bird_en, bus.o_bird_hold} !== 3'b001) begin
            n_fail++; $display("FAIL rst_flags: got %b expected 001", {bus.o_pipe_vis, bus.o_bird_en, bus.o_bird_hold});
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (int'(bus.o_pipe_x2[k]) !== SCREEN_W + k * SPACING) begin n_fail++; $display("FAIL rst_x2[%0d]: got %0d expected %0d", k, bus.o_pipe_x2[k], SCREEN_W + k * SPACING); end
            n_cmp++; if (int'(bus.o_pipe_x1[k]) !== SCREEN_W + k * SPACING - PIPE_W) begin n_fail++; $display("FAIL rst_x1[%0d]: got %0d expected %0d", k, bus.o_pipe_x1[k], SCREEN_W + k * SPACING - PIPE_W); end
            n_cmp++; if (int'(bus.o_gap_y1[k]) !== GAP_MIN) begin n_fail++; $display("FAIL rst_gap1[%0d]: got %0d expected %0d", k, bus.o_gap_y1[k], GAP_MIN); end
            n_cmp++; if (int'(bus.o_gap_y2[k]) !== GAP_MIN + GAP_H) begin n_fail++; $display("FAIL rst_gap2[%0d]: got %0d expected %0d", k, bus.o_gap_y2[k], GAP_MIN + GAP_H); end
        end
        // release with flap and animate held: only the third edge may start the game, with no scroll
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_flap    = 1'b1;
        bus.i_animate = 1'b1;
        step();
        n_cmp++; if (bus.o_state !== 2'b00) begin n_fail++; $display("FAIL sync_edge1: got %0d expected 0", bus.o_state); end
        step();
        n_cmp++; if (bus.o_state !== 2'b00) begin n_fail++; $display("FAIL sync_edge2: got %0d expected 0", bus.o_state); end
        model_start();
        step();
        bus.i_flap    = 1'b0;
        bus.i_animate = 1'b0;
        n_cmp++; if (bus.o_state !== 2'b01) begin n_fail++; $display("FAIL start_state: got %0d expected 1", bus.o_state); end
        n_cmp++; if ({bus.o_pipe_vis, bus.o_bird_en, bus.o_bird_hold} !== 3'b110) begin
            n_fail++; $display("FAIL start_flags: got %b expected 110", {bus.o_pipe_vis, bus.o_bird_en, bus.o_bird_hold});
        end
        n_cmp++; if (bus.o_score !== 8'd0) begin n_fail++; $display("FAIL start_score: got %0d expected 0", bus.o_score); end
        n_cmp++; if (bus.o_gap_y1[0] !== 12'd225) begin n_fail++; $display("FAIL start_gap_seed: got %0d expected 225", bus.o_gap_y1[0]); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (int'(bus.o_pipe_x2[k]) !== m_x2[k]) begin n_fail++; $display("FAIL start_x2[%0d]: got %0d expected %0d", k, bus.o_pipe_x2[k], m_x2[k]); end
            n_cmp++; if (int'(bus.o_gap_y1[k]) !== m_gap[k]) begin n_fail++; $display("FAIL start_gap1[%0d]: got %0d expected %0d", k, bus.o_gap_y1[k], m_gap[k]); end
        end
    endtask

    task automatic test_scroll();
        int c;
        set_bird(150, 110, 100, 120);
        for (int n = 1; n <= 340; n++) begin
            int idle;
            idle = $urandom_range(0, 2);
            repeat (idle) step();
            bus.i_bird_y1 = 12'($urandom_range(0, 400));
            bus.i_bird_y2 = bus.i_bird_y1 + 12'd20;
            bus.i_animate = 1'b1;
            model_scroll(150, c);
            step();
            bus.i_animate = 1'b0;
            n_cmp++; if (bus.o_state !== 2'b01) begin n_fail++; $display("FAIL scroll_state: got %0d expected 1", bus.o_state); end
            n_cmp++; if (int'(bus.o_score) !== m_score) begin n_fail++; $display("FAIL scroll_score: got %0d expected %0d", bus.o_score, m_score); end
            for (int k = 0; k < 3; k++) begin
                n_cmp++; if (int'(bus.o_pipe_x2[k]) !== m_x2[k]) begin n_fail++; $display("FAIL scroll_x2[%0d]: got %0d expected %0d", k, bus.o_pipe_x2[k], m_x2[k]); end
                n_cmp++; if (int'(bus.o_pipe_x1[k]) !== x1_of(m_x2[k])) begin n_fail++; $display("FAIL scroll_x1[%0d]: got %0d expected %0d", k, bus.o_pipe_x1[k], x1_of(m_x2[k])); end
                n_cmp++; if (int'(bus.o_gap_y1[k]) !== m_gap[k]) begin n_fail++; $display("FAIL scroll_gap1[%0d]: got %0d expected %0d", k, bus.o_gap_y1[k], m_gap[k]); end
                n_cmp++; if (int'(bus.o_gap_y2[k]) !== m_gap[k] + GAP_H) begin n_fail++; $display("FAIL scroll_gap2[%0d]: got %0d expected %0d", k, bus.o_gap_y2[k], m_gap[k] + GAP_H); end
            end
            if (n == 245) begin
                n_cmp++; if (bus.o_score !== 8'd0) begin n_fail++; $display("FAIL pre_cross_score: got %0d expected 0", bus.o_score); end
            end
            if (n == 246) begin
                n_cmp++; if (bus.o_pipe_x2[0] !== 12'd148) begin n_fail++; $display("FAIL cross_x2: got %0d expected 148", bus.o_pipe_x2[0]); end
                n_cmp++; if (bus.o_score !== 8'd1) begin n_fail++; $display("FAIL cross_score: got %0d expected 1", bus.o_score); end
            end
            if (n == 310) begin
                n_cmp++; if (bus.o_pipe_x1[0] !== 12'd0) begin n_fail++; $display("FAIL clamp_x1: got %0d expected 0", bus.o_pipe_x1[0]); end
            end
            if (n == 320) begin
                n_cmp++; if (bus.o_pipe_x2[0] !== 12'd660) begin n_fail++; $display("FAIL respawn_x2: got %0d expected 660", bus.o_pipe_x2[0]); end
            end
        end
    endtask

    task automatic test_saturate();
        int c;
        int extra;
        int iter;
        int prev;
        extra = 0;
        iter  = 0;
        bus.i_animate = 1'b1;
        while (extra < 3 && iter < 40000) begin
            prev = m_score;
            model_scroll(150, c);
            if (prev == 255 && c > 0) extra++;
            step();
            iter++;
            n_cmp++; if (int'(bus.o_score) !== m_score) begin n_fail++; $display("FAIL sat_score: got %0d expected %0d", bus.o_score, m_score); end
            for (int k = 0; k < 3; k++) begin
                n_cmp++; if (int'(bus.o_pipe_x2[k]) !== m_x2[k]) begin n_fail++; $display("FAIL sat_x2[%0d]: got %0d expected %0d", k, bus.o_pipe_x2[k], m_x2[k]); end
                n_cmp++; if (int'(bus.o_gap_y1[k]) !== m_gap[k]) begin n_fail++; $display("FAIL sat_gap1[%0d]: got %0d expected %0d", k, bus.o_gap_y1[k], m_gap[k]); end
            end
        end
        bus.i_animate = 1'b0;
        n_cmp++; if (extra < 3) begin n_fail++; $display("FAIL sat_budget: got %0d crossings at 255 expected 3", extra); end
        n_cmp++; if (bus.o_score !== 8'd255) begin n_fail++; $display("FAIL sat_final: got %0d expected 255", bus.o_score); end
    endtask

    task automatic test_hit_overlap();
        int kk;
        kk = 0;
        for (int k = 1; k < 3; k++) if (m_x2[k] > m_x2[kk]) kk = k;
        set_bird(m_x2[kk] - 20, m_x2[kk] - 5, 0, 10);
        bus.i_animate = 1'b1;
        step();
        bus.i_animate = 1'b0;
        n_cmp++; if (bus.o_hit !== 1'b1) begin n_fail++; $display("FAIL overlap_hit: got %0d expected 1", bus.o_hit); end
        n_cmp++; if (bus.o_state !== 2'b10) begin n_fail++; $display("FAIL overlap_state: got %0d expected 2", bus.o_state); end
        n_cmp++; if (int'(bus.o_score) !== m_score) begin n_fail++; $display("FAIL overlap_score: got %0d expected %0d", bus.o_score, m_score); end
        n_cmp++; if ({bus.o_pipe_vis, bus.o_bird_en, bus.o_bird_hold} !== 3'b100) begin
            n_fail++; $display("FAIL overlap_flags: got %b expected 100", {bus.o_pipe_vis, bus.o_bird_en, bus.o_bird_hold});
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (int'(bus.o_pipe_x2[k]) !== m_x2[k]) begin n_fail++; $display("FAIL overlap_x2[%0d]: got %0d expected %0d", k, bus.o_pipe_x2[k], m_x2[k]); end
        end
        step();
        n_cmp++; if (bus.o_hit !== 1'b0) begin n_fail++; $display("FAIL overlap_hit_pulse: got %0d expected 0", bus.o_hit); end
    endtask

    task automatic test_dead_count();
        set_bird(150, 110, 100, 120);
        for (int i = 1; i <= DEAD_FRAMES; i++) begin
            int idle;
            idle = $urandom_range(0, 3);
            repeat (idle) begin
                bus.i_flap = 1'($urandom_range(0, 1));
                step();
            end
            bus.i_flap    = 1'($urandom_range(0, 1));
            bus.i_animate = 1'b1;
            step();
            bus.i_animate = 1'b0;
            bus.i_flap    = 1'b0;
            n_cmp++; if (bus.o_state !== ((i < DEAD_FRAMES) ? 2'b10 : 2'b11)) begin
                n_fail++; $display("FAIL dead_state[%0d]: got %0d expected %0d", i, bus.o_state, (i < DEAD_FRAMES) ? 2 : 3);
            end
            n_cmp++; if (int'(bus.o_pipe_x2[0]) !== m_x2[0]) begin n_fail++; $display("FAIL dead_frozen: got %0d expected %0d", bus.o_pipe_x2[0], m_x2[0]); end
            n_cmp++; if (int'(bus.o_score) !== m_score) begin n_fail++; $display("FAIL dead_score: got %0d expected %0d", bus.o_score, m_score); end
        end
        n_cmp++; if (bus.o_pipe_vis !== 1'b1) begin n_fail++; $display("FAIL over_vis: got %0d expected 1", bus.o_pipe_vis); end
        bus.i_flap = 1'b1;
        step();
        bus.i_flap = 1'b0;
        n_cmp++; if (bus.o_state !== 2'b00) begin n_fail++; $display("FAIL over_to_idle: got %0d expected 0", bus.o_state); end
        n_cmp++; if (int'(bus.o_score) !== m_score) begin n_fail++; $display("FAIL idle_score_held: got %0d expected %0d", bus.o_score, m_score); end
        n_cmp++; if ({bus.o_pipe_vis, bus.o_bird_en, bus.o_bird_hold} !== 3'b001) begin
            n_fail++; $display("FAIL idle_flags: got %b expected 001", {bus.o_pipe_vis, bus.o_bird_en, bus.o_bird_hold});
        end
        bus.i_animate = 1'b1;
        repeat (3) step();
        bus.i_animate = 1'b0;
        n_cmp++; if (int'(bus.o_pipe_x2[1]) !== m_x2[1]) begin n_fail++; $display("FAIL idle_static: got %0d expected %0d", bus.o_pipe_x2[1], m_x2[1]); end
        bus.i_flap = 1'b1;
        model_start();
        step();
        bus.i_flap = 1'b0;
        n_cmp++; if (bus.o_state !== 2'b01) begin n_fail++; $display("FAIL replay_state: got %0d expected 1", bus.o_state); end
        n_cmp++; if (bus.o_score !== 8'd0) begin n_fail++; $display("FAIL replay_score: got %0d expected 0", bus.o_score); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (int'(bus.o_gap_y1[k]) !== m_gap[k]) begin n_fail++; $display("FAIL replay_gap1[%0d]: got %0d expected %0d", k, bus.o_gap_y1[k], m_gap[k]); end
        end
    endtask

    task automatic test_floor_hit();
        int c;
        set_bird(600, 560, 200, 220);
        bus.i_animate = 1'b1;
        repeat (25) begin
            model_scroll(600, c);
            step();
        end
        bus.i_animate = 1'b0;
        n_cmp++; if (bus.o_score !== 8'd1) begin n_fail++; $display("FAIL floor_pre_score: got %0d expected 1", bus.o_score); end
        set_bird(600, 560, FLOOR_Y - 20, FLOOR_Y);
        step();
        n_cmp++; if (bus.o_hit !== 1'b1) begin n_fail++; $display("FAIL floor_hit: got %0d expected 1", bus.o_hit); end
        n_cmp++; if (bus.o_state !== 2'b10) begin n_fail++; $display("FAIL floor_state: got %0d expected 2", bus.o_state); end
        step();
        n_cmp++; if (bus.o_hit !== 1'b0) begin n_fail++; $display("FAIL floor_hit_pulse: got %0d expected 0", bus.o_hit); end
        bus.i_animate = 1'b1;
        repeat (10) step();
        bus.i_animate = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (int'(bus.o_pipe_x2[k]) !== m_x2[k]) begin n_fail++; $display("FAIL floor_frozen[%0d]: got %0d expected %0d", k, bus.o_pipe_x2[k], m_x2[k]); end
        end
    endtask

    task automatic test_reset_dead();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (bus.o_state !== 2'b00) begin n_fail++; $display("FAIL mid_rst_state: got %0d expected 0", bus.o_state); end
        n_cmp++; if (bus.o_score !== 8'd0) begin n_fail++; $display("FAIL mid_rst_score: got %0d expected 0", bus.o_score); end
        n_cmp++; if (bus.o_bird_hold !== 1'b1) begin n_fail++; $display("FAIL mid_rst_hold: got %0d expected 1", bus.o_bird_hold); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (int'(bus.o_pipe_x2[k]) !== SCREEN_W + k * SPACING) begin n_fail++; $display("FAIL mid_rst_x2[%0d]: got %0d expected %0d", k, bus.o_pipe_x2[k], SCREEN_W + k * SPACING); end
            n_cmp++; if (int'(bus.o_gap_y1[k]) !== GAP_MIN) begin n_fail++; $display("FAIL mid_rst_gap[%0d]: got %0d expected %0d", k, bus.o_gap_y1[k], GAP_MIN); end
        end
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_flap = 1'b1;
        step();
        step();
        model_start();
        step();
        bus.i_flap = 1'b0;
        n_cmp++; if (bus.o_state !== 2'b01) begin n_fail++; $display("FAIL mid_rst_restart: got %0d expected 1", bus.o_state); end
        n_cmp++; if (bus.o_gap_y1[0] !== 12'd225) begin n_fail++; $display("FAIL mid_rst_gap0: got %0d expected 225", bus.o_gap_y1[0]); end
        n_cmp++; if (bus.o_gap_y1[1] !== 12'd262) begin n_fail++; $display("FAIL mid_rst_gap1: got %0d expected 262", bus.o_gap_y1[1]); end
        n_cmp++; if (bus.o_gap_y1[2] !== 12'd299) begin n_fail++; $display("FAIL mid_rst_gap2: got %0d expected 299", bus.o_gap_y1[2]); end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_scroll();
        test_saturate();
        test_hit_overlap();
        test_dead_count();
        test_floor_hit();
        test_reset_dead();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
